// File: rtl/vga_fb_pkg.sv
// Shared types and timing helpers for the VGA framebuffer engine.
// Timing totals and sync edges are derived from the porch parameters.
package vga_fb_pkg;

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_e;

  typedef logic bank_t;

  function automatic int timing_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int sync_start(
    input int act,
    input int fp
  );
    return act + fp;
  endfunction

  function automatic int sync_end(
    input int act,
    input int fp,
    input int sync
  );
    return act + fp + sync;
  endfunction

  localparam int H_TOTAL_DEF = timing_total(640, 16, 96, 48);
  localparam int V_TOTAL_DEF = timing_total(480, 10, 2, 33);
  localparam int HS_START_DEF = sync_start(640, 16);
  localparam int HS_END_DEF = sync_end(640, 16, 96);
  localparam int VS_START_DEF = sync_start(480, 10);
  localparam int VS_END_DEF = sync_end(480, 10, 2);

endpackage

// File: rtl/vga_fb_if.sv
// Producer-side port of the framebuffer engine: block writes
// plus the swap request/commit handshake.
interface vga_fb_if #(
  parameter int AW = 10,
  parameter int PIX_W = 8
);

  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [PIX_W-1:0] wr_data;
  logic             swap_req;
  logic             swap_pending;
  logic             swap_done;
  logic             front_bank;
  logic             wr_oob;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output swap_req,
    input  wr_ready,
    input  swap_pending,
    input  swap_done,
    input  front_bank,
    input  wr_oob
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  swap_req,
    output wr_ready,
    output swap_pending,
    output swap_done,
    output front_bank,
    output wr_oob
  );

endinterface

// File: rtl/vga_fb_dpram.sv
// Simple dual-port block RAM: one write port, one registered read.
// Address is {bank, block}; contents survive reset.
module vga_fb_dpram #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_fb_engine.sv
// VGA timing, double-buffered block framebuffer and pixel output.
// Define VGA_TESTPAT_EN to show colour bars until the first swap.
import vga_fb_pkg::*;

module vga_fb_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 20,
  parameter int PIX_W    = 8,
  parameter int SYNC_POL = 0
) (
  input  logic             vgaclk,
  input  logic             rst,
  vga_fb_if.slave          bus,
  output logic [9:0]       hc,
  output logic [9:0]       vc,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [PIX_W-1:0] pixel
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int HS_END = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int VS_END = sync_end(V_ACTIVE, V_FP, V_SYNC);
  localparam int DS_W = H_ACTIVE / SCALE;
  localparam int DS_H = V_ACTIVE / SCALE;
  localparam int DS = DS_W * DS_H;
  localparam int AW = $clog2(DS);
  localparam int SW = $clog2(SCALE);
  localparam logic POL = SYNC_POL[0];

  logic h_last;
  logic v_last;
  logic vblank;

  assign h_last = (hc == 10'(H_TOTAL - 1));
  assign v_last = (vc == 10'(V_TOTAL - 1));
  assign vblank = (hc == 10'd0) && (vc == 10'(V_ACTIVE));

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= h_last ? 10'd0 : hc + 10'd1;
      if (h_last) begin
        vc <= v_last ? 10'd0 : vc + 10'd1;
      end
    end
  end

  // Block index kept incrementally: column and row-base walk
  // in SCALE steps, so no divider sits on the read path.
  logic [SW-1:0] sx;
  logic [SW-1:0] sy;
  logic [AW-1:0] bx;
  logic [AW-1:0] row;
  logic [AW-1:0] blk;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      sx  <= '0;
      bx  <= '0;
      sy  <= '0;
      row <= '0;
    end else if (h_last) begin
      sx <= '0;
      bx <= '0;
      if (v_last) begin
        sy  <= '0;
        row <= '0;
      end else if (sy == SW'(SCALE - 1)) begin
        sy  <= '0;
        row <= row + AW'(DS_W);
      end else begin
        sy <= sy + 1'b1;
      end
    end else if (sx == SW'(SCALE - 1)) begin
      sx <= '0;
      bx <= bx + 1'b1;
    end else begin
      sx <= sx + 1'b1;
    end
  end

  assign blk = row + bx;

  swap_state_e state;
  swap_state_e state_n;
  logic        commit;
  bank_t       front;
  logic        done;
  logic        displayed;
  logic        oob;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.swap_req) begin
          state_n = PENDING;
        end
      end
      PENDING: begin
        if (vblank) begin
          state_n = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      front     <= 1'b0;
      done      <= 1'b0;
      displayed <= 1'b0;
    end else begin
      done <= commit;
      if (commit) begin
        front     <= ~front;
        displayed <= 1'b1;
      end
    end
  end

  logic accept;
  logic in_rng;
  logic we;

  assign accept = bus.wr_valid && bus.wr_ready;
  assign in_rng = ({1'b0, bus.wr_addr} < (AW + 1)'(DS));
  assign we     = accept && in_rng;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      oob <= 1'b0;
    end else if (accept && !in_rng) begin
      oob <= 1'b1;
    end
  end

  assign bus.wr_ready     = !rst && (state != PENDING);
  assign bus.swap_pending = (state == PENDING);
  assign bus.swap_done    = done;
  assign bus.front_bank   = front;
  assign bus.wr_oob       = oob;

  logic [PIX_W-1:0] ram_q;

  vga_fb_dpram #(
    .DW(PIX_W),
    .AW(AW + 1)
  ) u_ram (
    .clk  (vgaclk),
    .we   (we),
    .waddr({~front, bus.wr_addr}),
    .wdata(bus.wr_data),
    .raddr({front, blk}),
    .rdata(ram_q)
  );

  logic act;
  logic hs0;
  logic vs0;
  logic de1;
  logic hs1;
  logic vs1;

  assign act = (hc < 10'(H_ACTIVE)) && (vc < 10'(V_ACTIVE));
  assign hs0 = (hc >= 10'(HS_START)) && (hc < 10'(HS_END));
  assign vs0 = (vc >= 10'(VS_START)) && (vc < 10'(VS_END));

  logic [PIX_W-1:0] pix_n;

`ifdef VGA_TESTPAT_EN
  logic [2:0] bar1;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      bar1 <= '0;
    end else begin
      bar1 <= hc[9:7];
    end
  end

  always_comb begin
    pix_n = ram_q;
    if (!displayed) begin
      for (int i = 0; i < PIX_W; i++) begin
        pix_n[PIX_W-1-i] = bar1[2-(i%3)];
      end
    end
  end
`else
  always_comb begin
    pix_n = displayed ? ram_q : '0;
  end
`endif

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      de1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      de    <= 1'b0;
      hsync <= ~POL;
      vsync <= ~POL;
      pixel <= '0;
    end else begin
      de1   <= act;
      hs1   <= hs0;
      vs1   <= vs0;
      de    <= de1;
      hsync <= hs1 ? POL : ~POL;
      vsync <= vs1 ? POL : ~POL;
      pixel <= de1 ? pix_n : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_engine.sv
// Randomised directed bench for vga_fb_engine on a shrunken raster,
// checked every cycle against a frame-arithmetic reference model.
module tb_vga_fb_engine;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 12;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int SC = 4;
  localparam int PW = 8;
  localparam int POL = 0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DSW = HA / SC;
  localparam int DS = DSW * (VA / SC);
  localparam int AW = $clog2(DS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_fb_if #(.AW(AW), .PIX_W(PW)) bus ();

  logic [9:0]    hc;
  logic [9:0]    vc;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [PW-1:0] pixel;

  vga_fb_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE(SC), .PIX_W(PW), .SYNC_POL(POL)
  ) dut (
    .vgaclk(clk),
    .rst   (rst),
    .bus   (bus),
    .hc    (hc),
    .vc    (vc),
    .hsync (hsync),
    .vsync (vsync),
    .de    (de),
    .pixel (pixel)
  );

  typedef struct {
    bit v;
    int h;
    int vv;
    bit f;
    bit d;
  } pos_t;

  int   mt;
  bit   m_pend;
  bit   m_front;
  bit   m_oob;
  bit   m_disp;
  bit   m_done;
  logic [PW-1:0] mem [2][DS];
  pos_t s1;
  pos_t s2;
  int   pass_n;
  int   fail_n;
  int   total_n;
  int   done_n;

  function automatic int cur_h();
    return mt % HT;
  endfunction

  function automatic int cur_v();
    return (mt / HT) % VT;
  endfunction

  function automatic logic [PW-1:0] bars(input int h);
    logic [PW-1:0] c;
    int bar;
    bar = (h >> 7) & 7;
    c = '0;
    for (int i = 0; i < PW; i++) begin
      c[PW-1-i] = 1'((bar >> (2 - i % 3)) & 1);
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s t=%0d got %0h expected %0h", tag, mt, obs, exp);
    end
  endtask

  task automatic model_step();
    int h;
    int v;
    if (rst) begin
      mt = 0;
      m_pend = 0;
      m_front = 0;
      m_oob = 0;
      m_disp = 0;
      m_done = 0;
      s1.v = 0;
      s2.v = 0;
    end else begin
      h = cur_h();
      v = cur_v();
      s2 = s1;
      s1 = '{1'b1, h, v, m_front, m_disp};
      if (bus.wr_valid && !m_pend) begin
        if (int'(bus.wr_addr) < DS) mem[!m_front][bus.wr_addr] = bus.wr_data;
        else m_oob = 1;
      end
      m_done = 0;
      if (m_pend && h == 0 && v == VA) begin
        m_pend = 0;
        m_front = !m_front;
        m_done = 1;
        m_disp = 1;
      end else if (!m_pend && bus.swap_req) begin
        m_pend = 1;
      end
      mt++;
    end
  endtask

  task automatic check_all();
    bit e_de;
    bit e_hs;
    bit e_vs;
    logic [PW-1:0] e_pix;
    e_de = s2.v && s2.h < HA && s2.vv < VA;
    e_hs = s2.v && s2.h >= HA + HF && s2.h < HA + HF + HS;
    e_vs = s2.v && s2.vv >= VA + VF && s2.vv < VA + VF + VS;
    e_pix = '0;
    if (e_de) begin
      if (s2.d) e_pix = mem[s2.f][(s2.vv / SC) * DSW + s2.h / SC];
`ifdef VGA_TESTPAT_EN
      else e_pix = bars(s2.h);
`endif
    end
    chk("hc", 32'(hc), 32'(cur_h()));
    chk("vc", 32'(vc), 32'(cur_v()));
    chk("hsync", 32'(hsync), 32'(e_hs ? POL : 1 - POL));
    chk("vsync", 32'(vsync), 32'(e_vs ? POL : 1 - POL));
    chk("de", 32'(de), 32'(e_de));
    chk("pixel", 32'(pixel), 32'(e_pix));
    chk("wr_ready", 32'(bus.wr_ready), 32'(!rst && !m_pend));
    chk("swap_pending", 32'(bus.swap_pending), 32'(m_pend));
    chk("swap_done", 32'(bus.swap_done), 32'(m_done));
    chk("front_bank", 32'(bus.front_bank), 32'(m_front));
    chk("wr_oob", 32'(bus.wr_oob), 32'(m_oob));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    if (bus.swap_done === 1'b1) done_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 2 * HT * VT && !(cur_h() == h && cur_v() == v); i++)
      tick();
    chk("run_to_hc", 32'(hc), 32'(h));
    chk("run_to_vc", 32'(vc), 32'(v));
  endtask

  task automatic wr(input int a, input logic [PW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(a);
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
  endtask

  task automatic rand_writes(input int n, input int amax);
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'($urandom % 2);
      bus.wr_addr  = AW'($urandom_range(0, amax));
      bus.wr_data  = PW'($urandom);
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    pass_n = 0;
    fail_n = 0;
    total_n = 0;
    done_n = 0;
    mt = 0;
    s1.v = 0;
    s2.v = 0;
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.swap_req = 1'b0;
    run(3);
    rst = 1'b0;

    // fill back bank 1, blank display, then swap with a same-cycle write
    for (int i = 0; i < DS; i++) wr(i, PW'($urandom));
    rand_writes(40, DS - 1);
    bus.wr_valid = 1'b1;
    bus.wr_addr = AW'(5);
    bus.wr_data = 8'hE0;
    bus.swap_req = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    bus.swap_req = 1'b0;
    rand_writes(20, DS - 1);
    swap();
    rand_writes(20, DS - 1);
    run_to(0, VA);
    done_n = 0;
    run(HT * VT + 4);
    chk("one_swap_done", 32'(done_n), 32'd1);

    // fill bank 0 with an out-of-range write mixed in
    for (int i = 0; i < DS; i++) wr(i, PW'($urandom));
    wr(DS + 1, 8'hFF);
    rand_writes(30, 15);
    swap();
    run(2 * HT * VT);

    // request landing exactly on vblank start commits one frame later
    run_to(0, VA);
    swap();
    run(HT * VT + 4);

    // reset mid-frame with a swap pending; RAM is retained
    swap();
    run_to(7, 5);
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(HT * VT + 4);
    wr(3, 8'h5A);
    swap();
    run(2 * HT * VT);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
